// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD digits.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD decade digit: counts 0..9 on inc, wraps 9->0, flags when it sits at 9.
// The carry into this digit is built by the controller from the at_max chain.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic at_max
);

    // digit register: clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end

    assign at_max = (q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch sequencer over a chain of cascaded BCD digits.
// A prescaler divides clk into count ticks; the digit carry ripples in the
// same cycle as the tick. Optional lap freeze of the displayed value is
// built only when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_stop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    running,
    output logic                    overflow,
    output logic                    lap_active
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    sw_state_t                  state, state_nxt;
    logic [PW-1:0]              presc;
    logic                       tick;
    logic [NUM_DIGITS:0]        carry;
    logic [NUM_DIGITS-1:0]      at_max;
    bcd_t [NUM_DIGITS-1:0]      live;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state: clear beats start_stop
    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = IDLE;
        else if (start_stop) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // outputs decoded from the state register
    always_comb begin
        running = (state == RUN);
    end

    assign tick = (state == RUN) && (presc == PMAX);

    // prescaler advances only in RUN, so PAUSE keeps its phase for resume
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (clear)
            presc <= '0;
        else if (state == RUN)
            presc <= tick ? '0 : presc + 1'b1;
    end

    // ripple enables: digit i moves when tick and every lower digit is at 9
    assign carry[0] = tick;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        assign carry[i+1] = carry[i] & at_max[i];

        bcd_digit u_dig (
            .clk    (clk),
            .rst    (rst),
            .clr    (clear),
            .inc    (carry[i]),
            .q      (live[i]),
            .at_max (at_max[i])
        );
    end

    // sticky overflow: carry out of the top digit means all-9s wrapped to all-0s
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (clear)
            overflow <= 1'b0;
        else if (carry[NUM_DIGITS])
            overflow <= 1'b1;
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic                  lap_q;
    bcd_t [NUM_DIGITS-1:0] cap;

    // lap toggles the freeze; capture the live value seen on the turn-on edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q <= 1'b0;
            cap   <= '0;
        end else if (clear) begin
            lap_q <= 1'b0;
        end else if (lap && !start_stop && state != IDLE) begin
            lap_q <= !lap_q;
            if (!lap_q)
                cap <= live;
        end
    end

    assign lap_active = lap_q;
    assign digits     = lap_q ? cap : live;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign lap_active = 1'b0;
    assign digits     = live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (2 digits, tick every 2 clocks). A count-as-integer
// reference model predicts every output after every edge; directed scenarios
// and a random phase drive it. Define STOPWATCH_LAP_HOLD_EN for the lap build.
module tb_stopwatch_ctrl;

    localparam int ND   = 2;
    localparam int TD   = 2;
    localparam int MAXV = 10 ** ND;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_stop = 1'b0;
    logic          clear = 1'b0;
    logic          lap = 1'b0;
    logic [4*ND-1:0] digits;
    logic          running;
    logic          overflow;
    logic          lap_active;

    int nchk = 0;
    int nerr = 0;

    // model: count as a plain integer, mode, prescaler phase, flags
    int m_mode = M_IDLE;
    int m_ph   = 0;
    int m_cnt  = 0;
    int m_held = 0;
    bit m_ovf  = 1'b0;
    bit m_lap  = 1'b0;

    stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .digits     (digits),
        .running    (running),
        .overflow   (overflow),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ph = 0; m_cnt = 0; m_ovf = 1'b0; m_lap = 1'b0;
    endtask

    task automatic model_edge(input bit c, input bit s, input bit l);
        bit tk;
        int old;
        if (c) begin
            model_reset();
            return;
        end
        old = m_cnt;
        tk  = (m_mode == M_RUN) && (m_ph == TD - 1);
        if (m_mode == M_RUN)
            m_ph = (m_ph + 1) % TD;
        if (tk) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MAXV) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end
        end
`ifdef STOPWATCH_LAP_HOLD_EN
        if (l && !s && m_mode != M_IDLE) begin
            if (!m_lap)
                m_held = old;
            m_lap = !m_lap;
        end
`else
        if (l)
            m_lap = 1'b0;
`endif
        if (s)
            m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    endtask

    task automatic cmp_model();
        chk("m_digits",   32'(digits),     32'(m_lap ? to_bcd(m_held) : to_bcd(m_cnt)));
        chk("m_running",  32'(running),    32'(m_mode == M_RUN));
        chk("m_overflow", 32'(overflow),   32'(m_ovf));
        chk("m_lap",      32'(lap_active), 32'(m_lap));
    endtask

    // one clock edge with the given pulses; outputs checked 1 ns after the edge
    task automatic step(input bit c, input bit s, input bit l);
        clear = c; start_stop = s; lap = l;
        @(posedge clk);
        model_edge(c, s, l);
        #1;
        clear = 1'b0; start_stop = 1'b0; lap = 1'b0;
        cmp_model();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until(input string tag, input logic [7:0] v, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (digits == v) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    initial begin
        logic [7:0] prev;
        int         n;

        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits",   32'(digits),     32'h00);
        chk("rst_running",  32'(running),    32'd0);
        chk("rst_overflow", 32'(overflow),   32'd0);
        chk("rst_lap",      32'(lap_active), 32'd0);
        rst = 1'b0;
        model_reset();
        idle_steps(2);

        // 2. count, with a check on the 09 -> 10 ripple
        step(1'b0, 1'b1, 1'b0);
        chk("run_flag", 32'(running), 32'd1);
        prev = digits;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (prev == 8'h09 && digits != 8'h09)
                chk("ripple_09_10", 32'(digits), 32'h10);
            prev = digits;
        end
        chk("count_20", 32'(digits), 32'h10);

        // 3. pause at 05, then resume from the held phase
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run_until("reach_05", 8'h05, 40);
        step(1'b0, 1'b1, 1'b0);
        idle_steps(10);
        chk("pause_digits",  32'(digits),  32'h05);
        chk("pause_running", 32'(running), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        n = 0;
        while (digits == 8'h05 && n < 10) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("resume_phase", 32'(n), 32'd1);
        chk("resume_val",   32'(digits), 32'h06);

        // 4. full wrap sets overflow; clear drops it
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle_steps(200);
        chk("wrap_digits",   32'(digits),   32'h00);
        chk("wrap_overflow", 32'(overflow), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_running",  32'(running),  32'd0);

        // 5. clear beats start_stop; async reset mid-cycle
        step(1'b0, 1'b1, 1'b0);
        idle_steps(7);
        step(1'b1, 1'b1, 1'b0);
        chk("clrss_digits",  32'(digits),  32'h00);
        chk("clrss_running", 32'(running), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        run_until("reach_37", 8'h37, 200);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_digits",  32'(digits),  32'h00);
        chk("arst_running", 32'(running), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_steps(1);

        // 6. lap freeze
        step(1'b0, 1'b1, 1'b0);
        run_until("reach_12", 8'h12, 60);
        step(1'b0, 1'b0, 1'b1);
        idle_steps(9);
`ifdef STOPWATCH_LAP_HOLD_EN
        chk("lap_hold",   32'(digits),     32'h12);
        chk("lap_active", 32'(lap_active), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("lap_release", 32'(digits),    32'h17);
`else
        chk("nolap_live",   32'(digits),     32'h17);
        chk("nolap_active", 32'(lap_active), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("nolap_after",  32'(digits),     32'h17);
`endif

        // random pulses against the model
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
